spi_sram_slave: RTL and testbench

Synthesizable SPI SRAM target that consumes the serial bus driven by the team's Wishbone-to-SPI master. It emulates a 23LC-style serial SRAM in sequential mode for FPGA bring-up and simulation of the SERV SPI-RAM system. All SPI pins are oversampled in the system clock domain. No SCK-clocked logic.

---
 rtl/spi_sram_slave.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_spi_sram_slave.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_sram_slave.sv
// -----------------------------------------------------------------------------
// spi_sram_slave
//
// SPI target that behaves like a 23LC-style serial SRAM in sequential mode.
// Every SPI pin is oversampled in the system clock domain, so the system
// clock must run at least 8x faster than SCK. No logic is clocked by SCK.
//
// Supported commands: 0x03 READ, 0x02 WRITE (24-bit address, MSB first).
// Address bits above MEM_DEPTH_LOG2 are ignored, and sequential access wraps
// at the top of memory.
//
// Optional feature macro: SPI_SRAM_STATUS_EN
//   defined   : 0x05 RDSR returns the mode register (reset 0x40) for every
//               byte clocked out; 0x01 WRSR writes the next byte's bits [7:6]
//               into the mode register.
//   undefined : 0x05 and 0x01 are rejected like any other unknown command.
//
// Parameters:
//   MEM_DEPTH_LOG2  log2 of the byte capacity (24 or less)
//   INIT_FILE       memory image name; contents start uninitialized
//
// Ports:
//   clock        in   system clock
//   reset_n      in   asynchronous active-low reset
//   spi_sck      in   serial clock, mode 3 (idles high)
//   spi_ss       in   active-low chip select
//   spi_mosi     in   master data, sampled on SCK rise
//   spi_miso     out  slave data, updated on SCK fall
//   spi_miso_oe  out  high while MISO is driven (read states)
//   busy         out  high while synchronized chip select is low
//   cmd_err      out  one-clock pulse on an unsupported command byte
// -----------------------------------------------------------------------------
module spi_sram_slave #(
    parameter int MEM_DEPTH_LOG2 = 12,
    parameter     INIT_FILE      = ""
) (
    input  logic clock,
    input  logic reset_n,
    input  logic spi_sck,
    input  logic spi_ss,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic spi_miso_oe,
    output logic busy,
    output logic cmd_err
);

    localparam int AW    = MEM_DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WRITE,
        ST_READ,
        ST_DISCARD
`ifdef SPI_SRAM_STATUS_EN
        , ST_RDSR,
        ST_WRSR
`endif
    } state_t;

    // Pin synchronizers; sck_prev_q is the extra flop used for edge detection.
    logic sck_meta_q, sck_sync_q, sck_prev_q;
    logic ss_meta_q, ss_sync_q;
    logic mosi_meta_q, mosi_sync_q;

    state_t        state_q,    state_d;
    logic [2:0]    bit_cnt_q,  bit_cnt_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [6:0]    in_sr_q,    in_sr_d;
    logic [7:0]    out_sr_q,   out_sr_d;
    logic [AW-1:0] addr_q,     addr_d;
    logic          rd_flag_q,  rd_flag_d;
    logic          miso_q,     miso_d;
    logic          cmd_err_q,  cmd_err_d;
`ifdef SPI_SRAM_STATUS_EN
    logic [1:0]    mode_hi_q,  mode_hi_d;   // MODE_REG[7:6]; [5:0] read as zero
    logic [7:0]    mode_reg;
`endif

    logic [7:0]    mem [0:DEPTH-1];
    logic          mem_we;

    logic          sck_rise, sck_fall, byte_done;
    logic [7:0]    rx_byte;
    logic [AW-1:0] addr_inc, addr_shift;

    assign sck_rise  = sck_sync_q & ~sck_prev_q;
    assign sck_fall  = ~sck_sync_q & sck_prev_q;
    assign rx_byte   = {in_sr_q, mosi_sync_q};
    assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
    assign addr_inc  = addr_q + AW'(1);
    // Shifting each address byte into the low AW bits drops the ignored upper
    // address bits as they pass through, leaving addr24[AW-1:0] after 3 bytes.
    assign addr_shift = AW'({addr_q, rx_byte});
`ifdef SPI_SRAM_STATUS_EN
    assign mode_reg  = {mode_hi_q, 6'b0};
`endif

    // NOTE: next-state logic is purely combinational with every target given a
    // default first, so no latches can be inferred; only the always_ff blocks
    // below hold state, and they use non-blocking assignments exclusively.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        in_sr_d    = in_sr_q;
        out_sr_d   = out_sr_q;
        addr_d     = addr_q;
        rd_flag_d  = rd_flag_q;
        miso_d     = miso_q;
        cmd_err_d  = 1'b0;
        mem_we     = 1'b0;
`ifdef SPI_SRAM_STATUS_EN
        mode_hi_d  = mode_hi_q;
`endif

        if (ss_sync_q) begin
            // Deselect wins over any coincident SCK edge; a partial byte is lost.
            state_d    = ST_IDLE;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 2'd0;
            miso_d     = 1'b0;
        end else begin
            if (sck_rise && state_q != ST_IDLE && state_q != ST_DISCARD) begin
                in_sr_d   = rx_byte[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
            end

            unique case (state_q)
                ST_IDLE: state_d = ST_CMD;

                ST_CMD: begin
                    if (byte_done) begin
                        unique case (rx_byte)
                            8'h03: begin
                                rd_flag_d = 1'b1;
                                state_d   = ST_ADDR;
                            end
                            8'h02: begin
                                rd_flag_d = 1'b0;
                                state_d   = ST_ADDR;
                            end
`ifdef SPI_SRAM_STATUS_EN
                            8'h05: begin
                                out_sr_d = mode_reg;
                                state_d  = ST_RDSR;
                            end
                            8'h01: state_d = ST_WRSR;
`endif
                            default: begin
                                cmd_err_d = 1'b1;
                                state_d   = ST_DISCARD;
                            end
                        endcase
                    end
                end

                ST_ADDR: begin
                    if (byte_done) begin
                        addr_d     = addr_shift;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd2) begin
                            byte_cnt_d = 2'd0;
                            if (rd_flag_q) begin
                                // Preload so the next SCK fall shows bit 7.
                                out_sr_d = mem[addr_shift];
                                state_d  = ST_READ;
                            end else begin
                                state_d  = ST_WRITE;
                            end
                        end
                    end
                end

                ST_WRITE: begin
                    if (byte_done) begin
                        mem_we = 1'b1;
                        addr_d = addr_inc;
                    end
                end

                ST_READ: begin
                    if (sck_fall) begin
                        miso_d   = out_sr_q[7];
                        out_sr_d = {out_sr_q[6:0], 1'b0};
                    end
                    if (byte_done) begin
                        addr_d   = addr_inc;
                        out_sr_d = mem[addr_inc];
                    end
                end

`ifdef SPI_SRAM_STATUS_EN
                ST_RDSR: begin
                    if (sck_fall) begin
                        miso_d   = out_sr_q[7];
                        out_sr_d = {out_sr_q[6:0], 1'b0};
                    end
                    if (byte_done) out_sr_d = mode_reg;
                end

                ST_WRSR: begin
                    if (byte_done) begin
                        mode_hi_d = rx_byte[7:6];
                        state_d   = ST_DISCARD;
                    end
                end
`endif

                ST_DISCARD: ;

                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // SCK idles high and SS idles deasserted, so the synchronizers
            // start there to avoid a phantom edge or busy after reset.
            sck_meta_q  <= 1'b1;
            sck_sync_q  <= 1'b1;
            sck_prev_q  <= 1'b1;
            ss_meta_q   <= 1'b1;
            ss_sync_q   <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= 2'd0;
            in_sr_q     <= 7'd0;
            out_sr_q    <= 8'd0;
            addr_q      <= '0;
            rd_flag_q   <= 1'b0;
            miso_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
`ifdef SPI_SRAM_STATUS_EN
            mode_hi_q   <= 2'b01;
`endif
        end else begin
            sck_meta_q  <= spi_sck;
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            ss_meta_q   <= spi_ss;
            ss_sync_q   <= ss_meta_q;
            mosi_meta_q <= spi_mosi;
            mosi_sync_q <= mosi_meta_q;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            in_sr_q     <= in_sr_d;
            out_sr_q    <= out_sr_d;
            addr_q      <= addr_d;
            rd_flag_q   <= rd_flag_d;
            miso_q      <= miso_d;
            cmd_err_q   <= cmd_err_d;
`ifdef SPI_SRAM_STATUS_EN
            mode_hi_q   <= mode_hi_d;
`endif
        end
    end

    // NOTE: the storage array has no reset; its contents survive reset_n and
    // it maps onto plain block/distributed RAM.
    always_ff @(posedge clock) begin
        if (mem_we) mem[addr_q] <= rx_byte;
    end

    assign spi_miso = miso_q;
    assign cmd_err  = cmd_err_q;
    assign busy     = ~ss_sync_q;
`ifdef SPI_SRAM_STATUS_EN
    assign spi_miso_oe = ~ss_sync_q && (state_q == ST_READ || state_q == ST_RDSR);
`else
    assign spi_miso_oe = ~ss_sync_q && (state_q == ST_READ);
`endif

endmodule

// File: tb/tb_spi_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_sram_slave
//
// Table-driven bench for spi_sram_slave: each record is one SPI transaction
// (command, 24-bit address, up to two data bytes) with the bytes expected on
// MISO, the expected MISO enable, and the number of cmd_err pulses expected.
// Hand-written sequences cover a write aborted mid-byte and reset_n during a
// read.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_sram_slave;

    localparam int HALF = 8;   // system clocks per SCK half period (16x ratio)

    logic clock    = 1'b0;
    logic reset_n  = 1'b0;
    logic spi_sck  = 1'b1;
    logic spi_ss   = 1'b1;
    logic spi_mosi = 1'b0;
    logic spi_miso, spi_miso_oe, busy, cmd_err;

    int checks     = 0;
    int errors     = 0;
    int err_pulses = 0;

    spi_sram_slave #(.MEM_DEPTH_LOG2(12), .INIT_FILE("")) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .spi_sck     (spi_sck),
        .spi_ss      (spi_ss),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .busy        (busy),
        .cmd_err     (cmd_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (cmd_err === 1'b1) err_pulses <= err_pulses + 1;

    typedef struct {
        string       name;
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          nbytes;    // 1 or 2 data bytes
        logic [15:0] wdata;     // first byte in [15:8]
        logic [15:0] exp_rx;    // expected MISO bytes, first in [15:8]
        logic        exp_oe;    // MISO enable during data bytes
        int          exp_err;   // cmd_err pulses over the transaction
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Mode 3 master: drive MOSI on the falling edge, sample MISO just before
    // the rising edge. oe_all / oe_any summarize spi_miso_oe at sample points.
    task automatic spi_bits(input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx, output logic oe_all, output logic oe_any);
        rx     = 8'h00;
        oe_all = 1'b1;
        oe_any = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi_sck  = 1'b0;
            spi_mosi = tx[7-i];
            wait_clks(HALF);
            rx     = {rx[6:0], spi_miso};
            oe_all = oe_all & spi_miso_oe;
            oe_any = oe_any | spi_miso_oe;
            spi_sck = 1'b1;
            wait_clks(HALF);
        end
    endtask

    task automatic add_vec(input string name, input logic [7:0] cmd, input logic [23:0] addr,
                           input int nbytes, input logic [15:0] wdata, input logic [15:0] exp_rx,
                           input logic exp_oe, input int exp_err);
        vec_t v;
        v.name = name; v.cmd = cmd; v.addr = addr; v.nbytes = nbytes;
        v.wdata = wdata; v.exp_rx = exp_rx; v.exp_oe = exp_oe; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    task automatic run_txn(input vec_t v);
        logic [7:0] rx, tx, exp_b;
        logic       oe_all, oe_any, hdr_oe;
        int         start_err;
        start_err = err_pulses;
        hdr_oe    = 1'b0;
        spi_ss    = 1'b0;
        wait_clks(6);
        check({v.name, " busy"}, 32'(busy), 32'd1);
        spi_bits(v.cmd, 8, rx, oe_all, oe_any);
        hdr_oe = hdr_oe | oe_any;
        for (int i = 0; i < 3; i++) begin
            tx = v.addr[23 - 8*i -: 8];
            spi_bits(tx, 8, rx, oe_all, oe_any);
            hdr_oe = hdr_oe | oe_any;
        end
        check({v.name, " header oe"}, 32'(hdr_oe), 32'd0);
        for (int i = 0; i < v.nbytes; i++) begin
            tx    = (i == 0) ? v.wdata[15:8] : v.wdata[7:0];
            exp_b = (i == 0) ? v.exp_rx[15:8] : v.exp_rx[7:0];
            spi_bits(tx, 8, rx, oe_all, oe_any);
            check($sformatf("%s rx%0d", v.name, i), 32'(rx), 32'(exp_b));
            if (v.exp_oe) check($sformatf("%s oe%0d", v.name, i), 32'(oe_all), 32'd1);
            else          check($sformatf("%s oe%0d", v.name, i), 32'(oe_any), 32'd0);
        end
        wait_clks(HALF);
        spi_ss = 1'b1;
        wait_clks(6);
        check({v.name, " idle busy"}, 32'(busy), 32'd0);
        check({v.name, " idle oe"}, 32'(spi_miso_oe), 32'd0);
        check({v.name, " cmd_err pulses"}, 32'(err_pulses - start_err), 32'(v.exp_err));
    endtask

    initial begin
        logic [7:0] rx;
        logic       oe_all, oe_any;
        vec_t       v;

        add_vec("wr_10",  8'h02, 24'h000010, 2, 16'hA53C, 16'h0000, 1'b0, 0);
        add_vec("rd_10",  8'h03, 24'h000010, 2, 16'h0000, 16'hA53C, 1'b1, 0);
        add_vec("wr_fff", 8'h02, 24'h000FFF, 2, 16'h1122, 16'h0000, 1'b0, 0);
        add_vec("rd_fff", 8'h03, 24'h000FFF, 2, 16'h0000, 16'h1122, 1'b1, 0);
        add_vec("rd_000", 8'h03, 24'h000000, 1, 16'h0000, 16'h2200, 1'b1, 0);
        add_vec("wr_hi",  8'h02, 24'h00F010, 1, 16'h5A00, 16'h0000, 1'b0, 0);
        add_vec("rd_10b", 8'h03, 24'h000010, 2, 16'h0000, 16'h5A3C, 1'b1, 0);
        add_vec("bad_9f", 8'h9F, 24'h000010, 1, 16'hFF00, 16'h0000, 1'b0, 1);
        add_vec("rd_10c", 8'h03, 24'h000010, 2, 16'h0000, 16'h5A3C, 1'b1, 0);
        add_vec("wr_20",  8'h02, 24'h000020, 2, 16'hEEDD, 16'h0000, 1'b0, 0);
        add_vec("rd_20",  8'h03, 24'h000020, 2, 16'h0000, 16'hEEDD, 1'b1, 0);

        // Reset state
        wait_clks(3);
        check("reset miso", 32'(spi_miso), 32'd0);
        check("reset oe", 32'(spi_miso_oe), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset cmd_err", 32'(cmd_err), 32'd0);
        reset_n = 1'b1;
        wait_clks(5);

        foreach (vecs[i]) run_txn(vecs[i]);

        // Write one full byte to 0x20, then 4 bits of another, then deselect.
        spi_ss = 1'b0;
        wait_clks(6);
        spi_bits(8'h02, 8, rx, oe_all, oe_any);
        spi_bits(8'h00, 8, rx, oe_all, oe_any);
        spi_bits(8'h00, 8, rx, oe_all, oe_any);
        spi_bits(8'h20, 8, rx, oe_all, oe_any);
        spi_bits(8'h77, 8, rx, oe_all, oe_any);
        spi_bits(8'h99, 4, rx, oe_all, oe_any);
        wait_clks(HALF);
        spi_ss = 1'b1;
        wait_clks(6);
        v.name = "rd_partial"; v.cmd = 8'h03; v.addr = 24'h000020; v.nbytes = 2;
        v.wdata = 16'h0000; v.exp_rx = 16'h77DD; v.exp_oe = 1'b1; v.exp_err = 0;
        run_txn(v);

        // reset_n asserted in the middle of a read data byte.
        spi_ss = 1'b0;
        wait_clks(6);
        spi_bits(8'h03, 8, rx, oe_all, oe_any);
        spi_bits(8'h00, 8, rx, oe_all, oe_any);
        spi_bits(8'h00, 8, rx, oe_all, oe_any);
        spi_bits(8'h10, 8, rx, oe_all, oe_any);
        spi_bits(8'h00, 3, rx, oe_all, oe_any);
        check("mid-read oe", 32'(spi_miso_oe), 32'd1);
        check("mid-read 3 bits", 32'(rx), 32'h02);   // 0x5A = 010..., first 3 bits
        reset_n = 1'b0;
        #1;
        check("async reset miso", 32'(spi_miso), 32'd0);
        check("async reset oe", 32'(spi_miso_oe), 32'd0);
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset cmd_err", 32'(cmd_err), 32'd0);
        spi_ss  = 1'b1;
        spi_sck = 1'b1;
        wait_clks(4);
        reset_n = 1'b1;
        wait_clks(4);
        v.name = "rd_after_reset"; v.cmd = 8'h03; v.addr = 24'h000010; v.nbytes = 2;
        v.wdata = 16'h0000; v.exp_rx = 16'h5A3C; v.exp_oe = 1'b1; v.exp_err = 0;
        run_txn(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
